// File: rtl/isu_pkg.sv
// isu_pkg: shared dispatch/issue encodings, default widths and packed ISQ field positions.
//   ROB_STATE_*      : ROB state encodings; dispatch proceeds only in ROB_STATE_IDLE
//   PREG_W / ROBID_W : default physical-register and ROB-id widths
//   isq_*_pos        : LSB offsets of fields inside one isq_enq_data lane
//   lane layout (MSB..LSB) : {robid, sleep1, sleep2, payload, prd, prs1, prs2, need_to_wb, src1_is_reg, src2_is_reg}
package isu_pkg;
  typedef enum logic [1:0] {
    ROB_STATE_IDLE     = 2'd0,
    ROB_STATE_ROLLBACK = 2'd1,
    ROB_STATE_WALK     = 2'd2,
    ROB_STATE_FLUSH    = 2'd3
  } rob_state_e;
  localparam int PREG_W = 6;
  localparam int ROBID_W = 7;
  localparam int ISQ_FLAG_W = 3;
  function automatic int rob_lane_w(int pw, int gw);
    return pw + 2 * gw + 1;
  endfunction
  function automatic int isq_sleep2_pos(int pw, int gw);
    return pw + 3 * gw + ISQ_FLAG_W;
  endfunction
  function automatic int isq_sleep1_pos(int pw, int gw);
    return isq_sleep2_pos(pw, gw) + 1;
  endfunction
  function automatic int isq_robid_pos(int pw, int gw);
    return isq_sleep2_pos(pw, gw) + 2;
  endfunction
  function automatic int isq_lane_w(int pw, int gw, int rw);
    return isq_robid_pos(pw, gw) + rw;
  endfunction
endpackage

// File: rtl/disp_dep_check.sv
// disp_dep_check: intra-group RAW detector for a dispatch group.
//   lane_valid : lanes actually dispatched this cycle
//   need_to_wb : per-lane destination-write flag
//   prd/prs1/prs2 : flattened per-lane dest/source pregs
//   hit1/hit2  : source K of lane i is produced by an older dispatched lane j < i
//   preg 0 is the hard-wired zero register and never matches.
module disp_dep_check import isu_pkg::*; #(
  parameter int DISP_WIDTH = 2,
  parameter int PREG_WIDTH = PREG_W
) (
  input  logic [DISP_WIDTH-1:0]            lane_valid,
  input  logic [DISP_WIDTH-1:0]            need_to_wb,
  input  logic [DISP_WIDTH*PREG_WIDTH-1:0] prd,
  input  logic [DISP_WIDTH*PREG_WIDTH-1:0] prs1,
  input  logic [DISP_WIDTH*PREG_WIDTH-1:0] prs2,
  output logic [DISP_WIDTH-1:0]            hit1,
  output logic [DISP_WIDTH-1:0]            hit2
);
  always_comb begin
    hit1 = '0;
    hit2 = '0;
    for (int i = 1; i < DISP_WIDTH; i++) begin
      for (int j = 0; j < i; j++) begin
        hit1[i] = hit1[i] | (lane_valid[j] & need_to_wb[j] & (prd[j*PREG_WIDTH +: PREG_WIDTH] != '0) &
                             (prd[j*PREG_WIDTH +: PREG_WIDTH] == prs1[i*PREG_WIDTH +: PREG_WIDTH]));
        hit2[i] = hit2[i] | (lane_valid[j] & need_to_wb[j] & (prd[j*PREG_WIDTH +: PREG_WIDTH] != '0) &
                             (prd[j*PREG_WIDTH +: PREG_WIDTH] == prs2[i*PREG_WIDTH +: PREG_WIDTH]));
      end
    end
  end
endmodule

// File: rtl/disp_stage_n.sv
// disp_stage_n: N-wide dispatch stage buffering renamed instructions and dispatching to ROB and int ISQ.
//   clock/reset      : clock, synchronous active-high reset
//   flush_valid      : drops queue contents; no accept, no dispatch that cycle
//   in_*             : rename group (contiguous valids, all-or-nothing accept via in_ready)
//   rob_* / isq_*    : credit, state and base robid in; per-lane enqueue valids/data out
//   bt_*             : busy-table read (combinational) and busy-bit allocation
//   wb_valid/wb_prd  : wakeup broadcast, used only when DISP_WAKEUP_BYPASS_EN is defined
// Option: `define DISP_WAKEUP_BYPASS_EN masks bt_busy for a source being written back this cycle.
module disp_stage_n import isu_pkg::*; #(
  parameter int DISP_WIDTH    = 2,
  parameter int BUF_DEPTH     = 4,
  parameter int PAYLOAD_WIDTH = 234,
  parameter int PREG_WIDTH    = PREG_W,
  parameter int ROBID_WIDTH   = ROBID_W,
  parameter int CNT_WIDTH     = 3
) (
  input  logic                                                        clock,
  input  logic                                                        reset,
  input  logic                                                        flush_valid,
  input  logic [DISP_WIDTH-1:0]                                       in_valid,
  output logic                                                        in_ready,
  input  logic [DISP_WIDTH*PAYLOAD_WIDTH-1:0]                         in_payload,
  input  logic [DISP_WIDTH*PREG_WIDTH-1:0]                            in_prd,
  input  logic [DISP_WIDTH*PREG_WIDTH-1:0]                            in_prs1,
  input  logic [DISP_WIDTH*PREG_WIDTH-1:0]                            in_prs2,
  input  logic [DISP_WIDTH-1:0]                                       in_need_to_wb,
  input  logic [DISP_WIDTH-1:0]                                       in_src1_is_reg,
  input  logic [DISP_WIDTH-1:0]                                       in_src2_is_reg,
  input  logic [CNT_WIDTH-1:0]                                        rob_free_cnt,
  input  logic [1:0]                                                  rob_state,
  input  logic [ROBID_WIDTH-1:0]                                      rob_enq_base_robid,
  input  logic [CNT_WIDTH-1:0]                                        isq_free_cnt,
  output logic [DISP_WIDTH-1:0]                                       rob_enq_valid,
  output logic [DISP_WIDTH*(PAYLOAD_WIDTH+2*PREG_WIDTH+1)-1:0]        rob_enq_payload,
  output logic [DISP_WIDTH-1:0]                                       isq_enq_valid,
  output logic [DISP_WIDTH*(ROBID_WIDTH+2+PAYLOAD_WIDTH+3*PREG_WIDTH+3)-1:0] isq_enq_data,
  output logic [2*DISP_WIDTH*PREG_WIDTH-1:0]                          bt_rdaddr,
  input  logic [2*DISP_WIDTH-1:0]                                     bt_busy,
  output logic [DISP_WIDTH-1:0]                                       bt_alloc_en,
  output logic [DISP_WIDTH*PREG_WIDTH-1:0]                            bt_alloc_addr,
  input  logic                                                        wb_valid,
  input  logic [PREG_WIDTH-1:0]                                       wb_prd
);
  localparam int AW = $clog2(BUF_DEPTH);
  localparam int QW = AW + 1;
  localparam int PW = PAYLOAD_WIDTH;
  localparam int GW = PREG_WIDTH;
  localparam int RL = rob_lane_w(PW, GW);
  localparam int IL = isq_lane_w(PW, GW, ROBID_WIDTH);
  localparam int S2 = isq_sleep2_pos(PW, GW);
  localparam int S1 = isq_sleep1_pos(PW, GW);
  localparam int RP = isq_robid_pos(PW, GW);
  logic [PW-1:0] pay_q [BUF_DEPTH];
  logic [PW-1:0] pay_d [BUF_DEPTH];
  logic [GW-1:0] prd_q [BUF_DEPTH];
  logic [GW-1:0] prd_d [BUF_DEPTH];
  logic [GW-1:0] prs1_q [BUF_DEPTH];
  logic [GW-1:0] prs1_d [BUF_DEPTH];
  logic [GW-1:0] prs2_q [BUF_DEPTH];
  logic [GW-1:0] prs2_d [BUF_DEPTH];
  logic [2:0] flg_q [BUF_DEPTH];
  logic [2:0] flg_d [BUF_DEPTH];
  logic [QW-1:0] head_q, head_d, tail_q, tail_d, count_q, count_d;
  logic [QW-1:0] acc, n;
  logic go;
  logic [DISP_WIDTH-1:0] dv, h_ntw, h_r1, h_r2, hit1, hit2, byp1, byp2, sleep1, sleep2;
  logic [DISP_WIDTH*GW-1:0] h_prd, h_prs1, h_prs2;
  assign in_ready = ~reset & ~flush_valid & (count_q <= QW'(BUF_DEPTH - DISP_WIDTH));
  assign go = ~reset & ~flush_valid & (rob_state == ROB_STATE_IDLE);
  for (genvar i = 0; i < DISP_WIDTH; i++) begin : g_lane
    logic [AW-1:0] hidx;
    logic [PW-1:0] h_pay;
    logic busy1, busy2;
    assign hidx = head_q[AW-1:0] + AW'(i);
    assign h_pay = pay_q[hidx];
    assign h_prd[i*GW +: GW] = prd_q[hidx];
    assign h_prs1[i*GW +: GW] = prs1_q[hidx];
    assign h_prs2[i*GW +: GW] = prs2_q[hidx];
    assign {h_ntw[i], h_r1[i], h_r2[i]} = flg_q[hidx];
    // credits are thermometer-compared so dv is always a contiguous prefix of lanes
    assign dv[i] = go & (count_q > QW'(i)) & (rob_free_cnt > CNT_WIDTH'(i)) & (isq_free_cnt > CNT_WIDTH'(i));
    assign bt_rdaddr[i*GW +: GW] = h_prs1[i*GW +: GW];
    assign bt_rdaddr[(DISP_WIDTH+i)*GW +: GW] = h_prs2[i*GW +: GW];
`ifdef DISP_WAKEUP_BYPASS_EN
    assign byp1[i] = wb_valid & (wb_prd == h_prs1[i*GW +: GW]);
    assign byp2[i] = wb_valid & (wb_prd == h_prs2[i*GW +: GW]);
`else
    assign byp1[i] = 1'b0;
    assign byp2[i] = 1'b0;
`endif
    assign busy1 = bt_busy[i] & (h_prs1[i*GW +: GW] != '0) & ~byp1[i];
    assign busy2 = bt_busy[DISP_WIDTH+i] & (h_prs2[i*GW +: GW] != '0) & ~byp2[i];
    assign sleep1[i] = h_r1[i] & (busy1 | hit1[i]);
    assign sleep2[i] = h_r2[i] & (busy2 | hit2[i]);
    assign rob_enq_valid[i] = dv[i];
    assign isq_enq_valid[i] = dv[i];
    assign bt_alloc_en[i] = dv[i] & h_ntw[i];
    assign bt_alloc_addr[i*GW +: GW] = h_prd[i*GW +: GW];
    assign rob_enq_payload[i*RL +: RL] = {h_pay, h_prd[i*GW +: GW], {GW{1'b0}}, h_ntw[i]};
    assign isq_enq_data[i*IL+RP +: ROBID_WIDTH] = rob_enq_base_robid + ROBID_WIDTH'(i);
    assign isq_enq_data[i*IL+S1] = sleep1[i];
    assign isq_enq_data[i*IL+S2] = sleep2[i];
    assign isq_enq_data[i*IL +: S2] = {h_pay, h_prd[i*GW +: GW], h_prs1[i*GW +: GW], h_prs2[i*GW +: GW],
                                       h_ntw[i], h_r1[i], h_r2[i]};
  end
`ifndef DISP_WAKEUP_BYPASS_EN
  logic unused_wb;
  assign unused_wb = ^{wb_valid, wb_prd};
`endif
  disp_dep_check #(.DISP_WIDTH(DISP_WIDTH), .PREG_WIDTH(GW)) u_dep (
    .lane_valid(dv),
    .need_to_wb(h_ntw),
    .prd(h_prd),
    .prs1(h_prs1),
    .prs2(h_prs2),
    .hit1(hit1),
    .hit2(hit2)
  );
  always_comb begin
    acc = '0;
    n = '0;
    pay_d = pay_q;
    prd_d = prd_q;
    prs1_d = prs1_q;
    prs2_d = prs2_q;
    flg_d = flg_q;
    for (int i = 0; i < DISP_WIDTH; i++) begin
      acc = acc + QW'(in_valid[i] & in_ready);
      n = n + QW'(dv[i]);
      if (in_valid[i] & in_ready) begin
        pay_d[tail_q[AW-1:0] + AW'(i)] = in_payload[i*PW +: PW];
        prd_d[tail_q[AW-1:0] + AW'(i)] = in_prd[i*GW +: GW];
        prs1_d[tail_q[AW-1:0] + AW'(i)] = in_prs1[i*GW +: GW];
        prs2_d[tail_q[AW-1:0] + AW'(i)] = in_prs2[i*GW +: GW];
        flg_d[tail_q[AW-1:0] + AW'(i)] = {in_need_to_wb[i], in_src1_is_reg[i], in_src2_is_reg[i]};
      end
    end
    head_d = flush_valid ? tail_q : head_q + n;
    tail_d = tail_q + acc;
    count_d = flush_valid ? '0 : count_q + acc - n;
  end
  always_ff @(posedge clock) begin
    head_q <= reset ? '0 : head_d;
    tail_q <= reset ? '0 : tail_d;
    count_q <= reset ? '0 : count_d;
    pay_q <= pay_d;
    prd_q <= prd_d;
    prs1_q <= prs1_d;
    prs2_q <= prs2_d;
    flg_q <= flg_d;
  end
endmodule

// File: tb/tb_disp_stage_n.sv
// tb_disp_stage_n: queue-model bench for disp_stage_n with directed pins and random traffic.
module tb_disp_stage_n;
  localparam int W = 2, D = 4, P = 234, G = 6, R = 7, C = 3;
  localparam int RL = P + 2 * G + 1;
  localparam int IL = R + 2 + P + 3 * G + 3;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic flush_valid = 1'b0;
  logic [W-1:0] in_valid = '0;
  logic in_ready;
  logic [W*P-1:0] in_payload = '0;
  logic [W*G-1:0] in_prd = '0, in_prs1 = '0, in_prs2 = '0;
  logic [W-1:0] in_need_to_wb = '0, in_src1_is_reg = '0, in_src2_is_reg = '0;
  logic [C-1:0] rob_free_cnt = 3'd4, isq_free_cnt = 3'd4;
  logic [1:0] rob_state = 2'd0;
  logic [R-1:0] rob_enq_base_robid = '0;
  logic [W-1:0] rob_enq_valid, isq_enq_valid, bt_alloc_en;
  logic [W*RL-1:0] rob_enq_payload;
  logic [W*IL-1:0] isq_enq_data;
  logic [2*W*G-1:0] bt_rdaddr;
  logic [2*W-1:0] bt_busy;
  logic [W*G-1:0] bt_alloc_addr;
  logic wb_valid = 1'b0;
  logic [G-1:0] wb_prd = '0;
  logic [63:0] busy_tb = '0;
  typedef struct packed {
    logic [P-1:0] pay;
    logic [G-1:0] prd, prs1, prs2;
    logic ntw, r1, r2;
  } ent_t;
  ent_t mq[$];
  int checks = 0, errors = 0;

  disp_stage_n dut (
    .clock(clock), .reset(reset), .flush_valid(flush_valid),
    .in_valid(in_valid), .in_ready(in_ready), .in_payload(in_payload),
    .in_prd(in_prd), .in_prs1(in_prs1), .in_prs2(in_prs2),
    .in_need_to_wb(in_need_to_wb), .in_src1_is_reg(in_src1_is_reg), .in_src2_is_reg(in_src2_is_reg),
    .rob_free_cnt(rob_free_cnt), .rob_state(rob_state), .rob_enq_base_robid(rob_enq_base_robid),
    .isq_free_cnt(isq_free_cnt), .rob_enq_valid(rob_enq_valid), .rob_enq_payload(rob_enq_payload),
    .isq_enq_valid(isq_enq_valid), .isq_enq_data(isq_enq_data), .bt_rdaddr(bt_rdaddr),
    .bt_busy(bt_busy), .bt_alloc_en(bt_alloc_en), .bt_alloc_addr(bt_alloc_addr),
    .wb_valid(wb_valid), .wb_prd(wb_prd)
  );

  always #5 clock = ~clock;

  always_comb begin
    bt_busy = '0;
    for (int k = 0; k < 2 * W; k++) bt_busy[k] = busy_tb[bt_rdaddr[k*G +: G]];
  end

  task automatic chk(string nm, logic [IL-1:0] act, logic [IL-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  function automatic logic [R-1:0] robid_of(int i);
    return isq_enq_data[i*IL+IL-R +: R];
  endfunction
  function automatic logic s1_of(int i);
    return isq_enq_data[i*IL+IL-R-1];
  endfunction

  // model sleep rule: older dispatched producer wins, else busy (bypass-masked, preg 0 never busy)
  function automatic logic model_sleep(int i, logic r, logic [G-1:0] s);
    logic busy;
    busy = (s != 0) && busy_tb[s];
`ifdef DISP_WAKEUP_BYPASS_EN
    if (wb_valid && wb_prd == s) busy = 1'b0;
`endif
    if (!r) return 1'b0;
    for (int j = 0; j < i; j++)
      if (mq[j].ntw && mq[j].prd != 0 && mq[j].prd == s) return 1'b1;
    return busy;
  endfunction

  always @(negedge clock) begin : cmp
    int n;
    logic rdy;
    ent_t e, ne;
    logic [W-1:0] ev, ea;
    logic [R-1:0] rid;
    if (reset) begin
      chk("reset_valids", IL'({rob_enq_valid, isq_enq_valid, bt_alloc_en}), '0);
      mq.delete();
    end else begin
      rdy = (mq.size() <= D - W) && !flush_valid;
      n = (flush_valid || rob_state != 2'd0) ? 0 : mq.size();
      if (n > W) n = W;
      if (n > int'(rob_free_cnt)) n = int'(rob_free_cnt);
      if (n > int'(isq_free_cnt)) n = int'(isq_free_cnt);
      chk("in_ready", IL'(in_ready), IL'(rdy));
      ev = '0;
      ea = '0;
      for (int i = 0; i < n; i++) begin
        ev[i] = 1'b1;
        ea[i] = mq[i].ntw;
      end
      chk("enq_valids", IL'({rob_enq_valid, isq_enq_valid}), IL'({ev, ev}));
      chk("alloc_en", IL'(bt_alloc_en), IL'(ea));
      for (int i = 0; i < n; i++) begin
        e = mq[i];
        rid = R'((int'(rob_enq_base_robid) + i) % (1 << R));
        if (e.ntw) chk("alloc_addr", IL'(bt_alloc_addr[i*G +: G]), IL'(e.prd));
        chk("rob_payload", IL'(rob_enq_payload[i*RL +: RL]), IL'({e.pay, e.prd, 6'd0, e.ntw}));
        chk("isq_data", isq_enq_data[i*IL +: IL],
            {rid, model_sleep(i, e.r1, e.prs1), model_sleep(i, e.r2, e.prs2),
             e.pay, e.prd, e.prs1, e.prs2, e.ntw, e.r1, e.r2});
      end
      if (flush_valid) mq.delete();
      else begin
        repeat (n) void'(mq.pop_front());
        if (rdy)
          for (int k = 0; k < W; k++)
            if (in_valid[k]) begin
              ne.pay = in_payload[k*P +: P];
              ne.prd = in_prd[k*G +: G];
              ne.prs1 = in_prs1[k*G +: G];
              ne.prs2 = in_prs2[k*G +: G];
              ne.ntw = in_need_to_wb[k];
              ne.r1 = in_src1_is_reg[k];
              ne.r2 = in_src2_is_reg[k];
              mq.push_back(ne);
            end
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_in();
    in_valid = '0;
    flush_valid = 1'b0;
    rob_state = 2'd0;
    rob_free_cnt = 3'd4;
    isq_free_cnt = 3'd4;
    rob_enq_base_robid = '0;
    wb_valid = 1'b0;
    wb_prd = '0;
    busy_tb = '0;
  endtask

  task automatic set_lane(int l, logic [G-1:0] d, logic [G-1:0] s1, logic [G-1:0] s2, logic ntw, logic r1, logic r2);
    logic [255:0] t;
    t = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    in_payload[l*P +: P] = t[P-1:0];
    in_prd[l*G +: G] = d;
    in_prs1[l*G +: G] = s1;
    in_prs2[l*G +: G] = s2;
    in_need_to_wb[l] = ntw;
    in_src1_is_reg[l] = r1;
    in_src2_is_reg[l] = r2;
  endtask

  initial begin
    idle_in();
    repeat (3) step();
    reset = 1'b0;
    // basic two-lane enqueue then dispatch
    set_lane(0, 6'd5, 6'd0, 6'd0, 1'b1, 1'b0, 1'b0);
    set_lane(1, 6'd6, 6'd0, 6'd0, 1'b1, 1'b0, 1'b0);
    in_valid = 2'b11;
    rob_enq_base_robid = 7'h10;
    @(negedge clock);
    chk("t1_ready", IL'(in_ready), IL'(1'b1));
    step();
    in_valid = '0;
    @(negedge clock);
    chk("t1_valid", IL'(isq_enq_valid), IL'(2'b11));
    chk("t1_robid0", IL'(robid_of(0)), IL'(7'h10));
    chk("t1_robid1", IL'(robid_of(1)), IL'(7'h11));
    chk("t1_alloc_en", IL'(bt_alloc_en), IL'(2'b11));
    chk("t1_alloc_addr", IL'(bt_alloc_addr), IL'({6'd6, 6'd5}));
    step();
    // intra-group dependency
    set_lane(0, 6'd9, 6'd0, 6'd0, 1'b1, 1'b1, 1'b1);
    set_lane(1, 6'd10, 6'd9, 6'd3, 1'b1, 1'b1, 1'b1);
    in_valid = 2'b11;
    step();
    in_valid = '0;
    @(negedge clock);
    chk("t2_l0_s1", IL'(s1_of(0)), IL'(1'b0));
    chk("t2_l0_s2", IL'(isq_enq_data[IL-R-2]), IL'(1'b0));
    chk("t2_l1_s1", IL'(s1_of(1)), IL'(1'b1));
    chk("t2_l1_s2", IL'(isq_enq_data[2*IL-R-2]), IL'(1'b0));
    step();
    set_lane(1, 6'd10, 6'd9, 6'd3, 1'b1, 1'b0, 1'b1);
    in_valid = 2'b11;
    step();
    in_valid = '0;
    @(negedge clock);
    chk("t2_l1_s1_imm", IL'(s1_of(1)), IL'(1'b0));
    step();
    // ROB credit of one
    set_lane(0, 6'd1, 6'd0, 6'd0, 1'b1, 1'b0, 1'b0);
    set_lane(1, 6'd2, 6'd0, 6'd0, 1'b1, 1'b0, 1'b0);
    in_valid = 2'b11;
    step();
    in_valid = '0;
    rob_free_cnt = 3'd1;
    rob_enq_base_robid = 7'h20;
    @(negedge clock);
    chk("t3_valid_a", IL'(isq_enq_valid), IL'(2'b01));
    chk("t3_robid_a", IL'(robid_of(0)), IL'(7'h20));
    chk("t3_addr_a", IL'(bt_alloc_addr[G-1:0]), IL'(6'd1));
    step();
    rob_enq_base_robid = 7'h21;
    @(negedge clock);
    chk("t3_valid_b", IL'(isq_enq_valid), IL'(2'b01));
    chk("t3_robid_b", IL'(robid_of(0)), IL'(7'h21));
    chk("t3_addr_b", IL'(bt_alloc_addr[G-1:0]), IL'(6'd2));
    step();
    rob_free_cnt = 3'd4;
    // full queue, no ISQ credit
    isq_free_cnt = 3'd0;
    set_lane(0, 6'd3, 6'd0, 6'd0, 1'b1, 1'b0, 1'b0);
    set_lane(1, 6'd4, 6'd0, 6'd0, 1'b1, 1'b0, 1'b0);
    in_valid = 2'b11;
    step();
    set_lane(0, 6'd7, 6'd0, 6'd0, 1'b1, 1'b0, 1'b0);
    set_lane(1, 6'd8, 6'd0, 6'd0, 1'b1, 1'b0, 1'b0);
    step();
    in_valid = '0;
    @(negedge clock);
    chk("t4_full_ready", IL'(in_ready), IL'(1'b0));
    chk("t4_full_valid", IL'(isq_enq_valid), IL'(2'b00));
    step();
    isq_free_cnt = 3'd2;
    @(negedge clock);
    chk("t4_drain_valid", IL'(isq_enq_valid), IL'(2'b11));
    chk("t4_no_credit_ready", IL'(in_ready), IL'(1'b0));
    step();
    @(negedge clock);
    chk("t4_ready_after", IL'(in_ready), IL'(1'b1));
    step();
    isq_free_cnt = 3'd4;
    // robid wrap
    set_lane(0, 6'd11, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0);
    set_lane(1, 6'd12, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0);
    in_valid = 2'b11;
    step();
    in_valid = '0;
    rob_enq_base_robid = 7'h7F;
    @(negedge clock);
    chk("t5_robid0", IL'(robid_of(0)), IL'(7'h7F));
    chk("t5_robid1", IL'(robid_of(1)), IL'(7'h00));
    step();
    rob_enq_base_robid = '0;
    // flush with three queued
    isq_free_cnt = 3'd0;
    in_valid = 2'b11;
    step();
    in_valid = 2'b01;
    step();
    flush_valid = 1'b1;
    in_valid = 2'b11;
    isq_free_cnt = 3'd4;
    @(negedge clock);
    chk("t6_flush_ready", IL'(in_ready), IL'(1'b0));
    chk("t6_flush_valids", IL'({rob_enq_valid, isq_enq_valid, bt_alloc_en}), '0);
    step();
    flush_valid = 1'b0;
    in_valid = '0;
    @(negedge clock);
    chk("t6_empty_valid", IL'(isq_enq_valid), IL'(2'b00));
    chk("t6_empty_ready", IL'(in_ready), IL'(1'b1));
    step();
    // wakeup bypass on a busy source
    set_lane(0, 6'd0, 6'd12, 6'd0, 1'b0, 1'b1, 1'b0);
    in_valid = 2'b01;
    step();
    in_valid = '0;
    busy_tb[12] = 1'b1;
    wb_valid = 1'b1;
    wb_prd = 6'd12;
    @(negedge clock);
`ifdef DISP_WAKEUP_BYPASS_EN
    chk("t6_bypass_s1", IL'(s1_of(0)), IL'(1'b0));
`else
    chk("t6_nobypass_s1", IL'(s1_of(0)), IL'(1'b1));
`endif
    step();
    idle_in();
    // reset mid-operation drops the queue
    isq_free_cnt = 3'd0;
    in_valid = 2'b11;
    step();
    in_valid = '0;
    isq_free_cnt = 3'd4;
    reset = 1'b1;
    step();
    reset = 1'b0;
    @(negedge clock);
    chk("rst_drop", IL'(isq_enq_valid), IL'(2'b00));
    step();
    // random traffic
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 199) == 0);
      flush_valid = ($urandom_range(0, 15) == 0);
      rob_state = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      rob_free_cnt = 3'($urandom_range(0, 7));
      isq_free_cnt = 3'($urandom_range(0, 7));
      rob_enq_base_robid = 7'($urandom);
      in_valid = 2'((1 << $urandom_range(0, 2)) - 1);
      for (int l = 0; l < W; l++)
        set_lane(l, 6'($urandom_range(0, 7)), 6'($urandom_range(0, 7)), 6'($urandom_range(0, 7)),
                 1'($urandom), 1'($urandom), 1'($urandom));
      if ($urandom_range(0, 7) == 0) busy_tb = {$urandom, $urandom};
      wb_valid = 1'($urandom);
      wb_prd = 6'($urandom_range(0, 7));
      step();
    end
    reset = 1'b0;
    idle_in();
    repeat (4) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
